// File: rtl/sobel_thr_ctrl_pkg.sv
// sobel_ctrl_pkg: shared state type, widths and saturating helpers
// for the Sobel threshold controller.
package sobel_ctrl_pkg;

  localparam int THR_W = 11;
  localparam int CNT_W = 20;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    ACTIVE,
    UPDATE
  } state_t;

  function automatic logic [THR_W-1:0] thr_step(
    input logic [THR_W-1:0] thr,
    input logic [7:0]       stp,
    input logic             up,
    input logic [THR_W-1:0] lo,
    input logic [THR_W-1:0] hi
  );
    logic [THR_W:0] t;
    logic [THR_W:0] s;
    logic [THR_W:0] r;
    t = {1'b0, thr};
    s = {{(THR_W-7){1'b0}}, stp};
    if (up) begin
      r = t + s;
      if (r > {1'b0, hi}) r = {1'b0, hi};
    end else begin
      if (t < ({1'b0, lo} + s)) r = {1'b0, lo};
      else r = t - s;
    end
    return r[THR_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(
    input logic [CNT_W-1:0] c
  );
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sobel_thr_ctrl_if.sv
// Video handshake between the Sobel stage and its controller:
// timing/edge stream in, masked edge stream out.
interface sobel_thr_ctrl_if;

  logic vs_in;
  logic hs_in;
  logic de_in;
  logic edge_in;
  logic mask_dout;
  logic mask_de;

  modport master (
    output vs_in, hs_in, de_in, edge_in,
    input  mask_dout, mask_de
  );

  modport slave (
    input  vs_in, hs_in, de_in, edge_in,
    output mask_dout, mask_de
  );

endinterface

// File: rtl/sobel_thr_ctrl_pos.sv
// sobel_pos_cnt: pixel/line position from de timing, 3x3 border
// flag for the current pixel, and sticky geometry error.
module sobel_pos_cnt #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic sof,
  input  logic de_in,
  output logic border,
  output logic line_err
);

  localparam int CW = $clog2(H_ACTIVE + 1);
  localparam int RW = $clog2(V_ACTIVE + 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          de_d;

  // a frame-start pixel sits at (0,0) of the new frame
  assign cur_col = sof ? '0 : col;
  assign cur_row = sof ? '0 : row;

  assign border = (cur_row == '0) ||
                  (cur_row >= RW'(V_ACTIVE - 1)) ||
                  (cur_col == '0) ||
                  (cur_col >= CW'(H_ACTIVE - 1));

  // position counters, saturating, with sticky overrun detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      de_d     <= 1'b0;
      line_err <= 1'b0;
    end else if (clr) begin
      col  <= '0;
      row  <= '0;
      de_d <= 1'b0;
    end else begin
      de_d <= de_in;
      if (sof) begin
        row <= '0;
        col <= de_in ? CW'(1) : '0;
      end else if (de_in) begin
        if (col != CW'(H_ACTIVE)) col <= col + CW'(1);
        if ((col == CW'(H_ACTIVE)) || (row == RW'(V_ACTIVE)))
          line_err <= 1'b1;
      end else if (de_d) begin
        col <= '0;
        if (row != RW'(V_ACTIVE)) row <= row + RW'(1);
      end
    end
  end

endmodule

// File: rtl/sobel_thr_ctrl.sv
// sobel_thr_ctrl: frame sequencer, border mask and adaptive threshold.
// Define SOBEL_THR_CTRL_STATS_EN to expose the per-frame edge count.
module sobel_thr_ctrl
  import sobel_ctrl_pkg::*;
#(
  parameter int               H_ACTIVE = 640,
  parameter int               V_ACTIVE = 480,
  parameter logic [THR_W-1:0] THR_INIT = 11'd200,
  parameter logic [THR_W-1:0] THR_MIN  = 11'd16,
  parameter logic [THR_W-1:0] THR_MAX  = 11'd2000,
  parameter logic [CNT_W-1:0] HYST     = 20'd256
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             auto_en,
  input  logic [THR_W-1:0] thr_manual,
  input  logic [CNT_W-1:0] target_cnt,
  input  logic [7:0]       step,
  sobel_thr_ctrl_if.slave  vid,
  output logic [THR_W-1:0] threshold,
  output logic             frame_done,
  output logic             line_err,
  output logic [CNT_W-1:0] frame_edge_cnt
);

  state_t           state;
  logic             vs_d;
  logic             sof;
  logic             border;
  logic             px_edge;
  logic             pos_clr;
  logic             unused;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] snap;
  logic [CNT_W:0]   cnt_w;
  logic [CNT_W:0]   tgt_w;
  logic [CNT_W:0]   hyst_w;
  logic             go_up;
  logic             go_dn;
  logic [THR_W-1:0] thr_idle;
  logic [THR_W-1:0] thr_next;

  assign unused  = vid.hs_in;
  assign sof     = vid.vs_in & ~vs_d;
  assign pos_clr = (state == IDLE);
  assign px_edge = vid.de_in & ~vid.edge_in & ~border;

  assign cnt_w  = {1'b0, snap};
  assign tgt_w  = {1'b0, target_cnt};
  assign hyst_w = {1'b0, HYST};
  assign go_up  = cnt_w > (tgt_w + hyst_w);
  assign go_dn  = (cnt_w + hyst_w) < tgt_w;

  assign thr_idle = auto_en ? THR_INIT : thr_manual;

  sobel_pos_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_pos (
    .clk      (pclk),
    .rst_n    (rst_n),
    .clr      (pos_clr),
    .sof      (sof),
    .de_in    (vid.de_in),
    .border   (border),
    .line_err (line_err)
  );

  // vsync history for rising-edge frame start
  always_ff @(posedge pclk) begin
    vs_d <= vid.vs_in;
  end

  // per-frame threshold decision from the last frame's edge count
  always_comb begin
    thr_next = threshold;
    if (!auto_en)
      thr_next = thr_manual;
    else if (go_up)
      thr_next = thr_step(threshold, step, 1'b1, THR_MIN, THR_MAX);
    else if (go_dn)
      thr_next = thr_step(threshold, step, 1'b0, THR_MIN, THR_MAX);
  end

  // frame sequencer with edge counter and registered outputs
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state      <= WAIT_VS;
      threshold  <= THR_INIT;
      frame_done <= 1'b0;
      cnt        <= '0;
      snap       <= '0;
    end else if (!enable) begin
      state      <= IDLE;
      threshold  <= thr_idle;
      frame_done <= 1'b0;
      cnt        <= '0;
      snap       <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          threshold <= thr_idle;
          state     <= WAIT_VS;
        end
        WAIT_VS: begin
          if (sof) begin
            state <= ACTIVE;
            cnt   <= CNT_W'(px_edge);
          end
        end
        ACTIVE: begin
          if (sof) begin
            state      <= UPDATE;
            frame_done <= 1'b1;
            snap       <= cnt;
            cnt        <= CNT_W'(px_edge);
          end else if (px_edge) begin
            cnt <= cnt_inc(cnt);
          end
        end
        UPDATE: begin
          state     <= ACTIVE;
          threshold <= thr_next;
          if (px_edge) cnt <= cnt_inc(cnt);
        end
        default: state <= WAIT_VS;
      endcase
    end
  end

  // output mask: border and blanking never report an edge
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      vid.mask_dout <= 1'b1;
      vid.mask_de   <= 1'b0;
    end else begin
      vid.mask_dout <= ~vid.de_in | vid.edge_in | border;
      vid.mask_de   <= vid.de_in;
    end
  end

`ifdef SOBEL_THR_CTRL_STATS_EN
  // last completed frame's edge count
  always_ff @(posedge pclk) begin
    if (!rst_n)
      frame_edge_cnt <= '0;
    else if (enable && (state == UPDATE))
      frame_edge_cnt <= snap;
  end
`else
  assign frame_edge_cnt = '0;
`endif

endmodule

// File: tb/tb_sobel_thr_ctrl.sv
// tb_sobel_thr_ctrl: directed frames on an 8x4 raster with a
// mask scoreboard and threshold/frame-level checks.
module tb_sobel_thr_ctrl;
  import sobel_ctrl_pkg::*;

  localparam int H = 8;
  localparam int V = 4;

`ifdef SOBEL_THR_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        auto_en;
  logic [10:0] thr_manual;
  logic [19:0] target_cnt;
  logic [7:0]  step;
  logic [10:0] threshold;
  logic        frame_done;
  logic        line_err;
  logic [19:0] frame_edge_cnt;

  int tests = 0;
  int fails = 0;
  int fd_cnt = 0;
  int ecnt = 0;
  int n_edges;
  int fd_before;
  int exp_thr;
  logic [1:0] sb_q[$];

  sobel_thr_ctrl_if vid();

  sobel_thr_ctrl #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .THR_INIT (11'd200),
    .THR_MIN  (11'd16),
    .THR_MAX  (11'd2000),
    .HYST     (20'd2)
  ) dut (
    .pclk           (pclk),
    .rst_n          (rst_n),
    .enable         (enable),
    .auto_en        (auto_en),
    .thr_manual     (thr_manual),
    .target_cnt     (target_cnt),
    .step           (step),
    .vid            (vid),
    .threshold      (threshold),
    .frame_done     (frame_done),
    .line_err       (line_err),
    .frame_edge_cnt (frame_edge_cnt)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vs, input logic de, input logic e,
                       input int r, input int c, input bit chk);
    logic brd;
    logic [1:0] ex;
    vid.vs_in   = vs;
    vid.hs_in   = ~de & ~vs;
    vid.de_in   = de;
    vid.edge_in = e;
    brd = (r == 0) || (r == V-1) || (c == 0) || (c == H-1);
    if (chk) sb_q.push_back({de, de ? (e | brd) : 1'b1});
    if (de && !e && !brd) ecnt++;
    @(posedge pclk);
    #1;
    if (chk && sb_q.size() > 0) begin
      ex = sb_q.pop_front();
      check("mask_de", 32'(vid.mask_de), 32'(ex[1]));
      check("mask_dout", 32'(vid.mask_dout), 32'(ex[0]));
    end
  endtask

  task automatic vsync();
    drive(1'b1, 1'b0, 1'b1, 0, 0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 0, 0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
  endtask

  // mode 0: every pixel an edge, 1: no edges, 2: random
  task automatic body(input int mode);
    logic e;
    ecnt = 0;
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        e = (mode == 0) ? 1'b0 :
            (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        drive(1'b0, 1'b1, e, r, c, 1'b1);
      end
      drive(1'b0, 1'b0, 1'b1, r, 0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, r, 0, 1'b1);
    end
  endtask

  initial begin
    vid.vs_in = 1'b0; vid.hs_in = 1'b0;
    vid.de_in = 1'b0; vid.edge_in = 1'b1;
    rst_n = 1'b0; enable = 1'b1; auto_en = 1'b1;
    thr_manual = 11'd100; target_cnt = 20'd4; step = 8'd50;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_thr", 32'(threshold), 200);
    check("rst_state", 32'(dut.state), 32'(WAIT_VS));
    check("rst_mask_de", 32'(vid.mask_de), 0);
    check("rst_mask_dout", 32'(vid.mask_dout), 1);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_line_err", 32'(line_err), 0);
    check("rst_fec", 32'(frame_edge_cnt), 0);
    rst_n = 1'b1;

    // auto: 12 interior edges, target 4 -> up
    vsync();
    check("first_vs_no_pulse", 32'(fd_cnt), 0);
    body(0);
    n_edges = ecnt;
    vsync();
    check("auto_up_pulse", 32'(fd_cnt), 1);
    check("auto_up_thr", 32'(threshold), 250);
    check("auto_up_fec", 32'(frame_edge_cnt), STATS ? 32'(n_edges) : 0);

    // reset in the middle of a line at col 3
    for (int c = 0; c < 3; c++) drive(1'b0, 1'b1, 1'b0, 0, c, 1'b0);
    vid.de_in = 1'b1; vid.edge_in = 1'b0; rst_n = 1'b0;
    @(posedge pclk);
    #1;
    check("midrst_thr", 32'(threshold), 200);
    check("midrst_state", 32'(dut.state), 32'(WAIT_VS));
    check("midrst_mask_de", 32'(vid.mask_de), 0);
    check("midrst_fec", 32'(frame_edge_cnt), 0);
    rst_n = 1'b1;
    for (int c = 4; c < H; c++) drive(1'b0, 1'b1, 1'b0, 0, c, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    fd_before = fd_cnt;
    vsync();
    check("midrst_no_pulse", 32'(fd_cnt), 32'(fd_before));
    body(0);
    vsync();
    check("midrst_second_vs_pulse", 32'(fd_cnt), 32'(fd_before + 1));
    check("midrst_thr_up", 32'(threshold), 250);

    // auto: no edges, target 10 -> down
    target_cnt = 20'd10;
    body(1);
    vsync();
    check("auto_dn_thr", 32'(threshold), 200);
    check("auto_dn_fec", 32'(frame_edge_cnt), 0);

    // manual value written mid-frame waits for UPDATE
    auto_en = 1'b0;
    thr_manual = 11'd300;
    body(2);
    check("manual_hold", 32'(threshold), 200);
    n_edges = ecnt;
    vsync();
    check("manual_apply", 32'(threshold), 300);
    check("rand_fec", 32'(frame_edge_cnt), STATS ? 32'(n_edges) : 0);
    body(1);
    vsync();
    check("manual_held", 32'(threshold), 300);

    // upper saturation
    thr_manual = 11'd1990;
    body(1);
    vsync();
    check("preset_1990", 32'(threshold), 1990);
    auto_en = 1'b1;
    target_cnt = 20'd4;
    body(0);
    vsync();
    check("sat_max", 32'(threshold), 2000);
    check("sat_max_fec", 32'(frame_edge_cnt), STATS ? 12 : 0);

    // lower saturation
    auto_en = 1'b0;
    thr_manual = 11'd40;
    body(1);
    vsync();
    check("preset_40", 32'(threshold), 40);
    auto_en = 1'b1;
    target_cnt = 20'd10;
    body(1);
    vsync();
    check("sat_min", 32'(threshold), 16);

    // random frame: band is 4..8 edges around target 6
    target_cnt = 20'd6;
    body(2);
    n_edges = ecnt;
    exp_thr = (n_edges > 8) ? 66 : 16;
    vsync();
    check("rand_thr", 32'(threshold), 32'(exp_thr));
    check("rand2_fec", 32'(frame_edge_cnt), STATS ? 32'(n_edges) : 0);

    // 9-pixel de run sets sticky line_err
    check("line_err_clean", 32'(line_err), 0);
    for (int c = 0; c < H + 1; c++) drive(1'b0, 1'b1, 1'b1, 0, c, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    check("line_err_set", 32'(line_err), 1);
    vsync();
    body(1);
    vsync();
    check("line_err_sticky", 32'(line_err), 1);

    // enable low -> IDLE next cycle
    enable = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
    check("idle_state", 32'(dut.state), 32'(IDLE));
    check("idle_thr_auto", 32'(threshold), 200);
    auto_en = 1'b0;
    thr_manual = 11'd123;
    drive(1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
    check("idle_thr_manual", 32'(threshold), 123);
    check("idle_line_err", 32'(line_err), 1);
    enable = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
    check("resume_state", 32'(dut.state), 32'(WAIT_VS));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
